// File: rtl/fmov_rs_pkg.sv
// Shared FPR move/sign-op types: CDB bus struct, ROB tag width, op encodings and tag matching.
package fmov_rs_pkg;

  localparam int unsigned ROB_WIDTH = 6;

  localparam logic [1:0] FMOV  = 2'b00;
  localparam logic [1:0] FNEG  = 2'b01;
  localparam logic [1:0] FABS  = 2'b10;
  localparam logic [1:0] FNABS = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/fmov_rs_pick.sv
// Oldest-ready priority picker: request 0 is oldest and wins; one-hot grant plus any-request.
module fmov_rs_pick #(
  parameter int unsigned N_REQ = 5
) (
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fmov_rs.sv
// Compacting reservation station for fmov/fneg/fabs/fnabs with CDB wakeup and 1-cycle dispatch.
// Define FMOV_RS_BYPASS_EN to let the issuing instruction dispatch in its own issue cycle.
module fmov_rs
  import fmov_rs_pkg::*;
#(
  parameter int unsigned N_ENTRY   = 4,
  parameter int unsigned ROB_WIDTH = fmov_rs_pkg::ROB_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [1:0]           issue_op,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  input  cdb_t                 opd_in,
  input  cdb_t                 cdb_in,
  output logic                 cdb_req_valid,
  input  logic                 cdb_req_ready,
  output cdb_t                 result
);

  typedef struct packed {
    logic                 valid;
    logic [1:0]           op;
    logic [ROB_WIDTH-1:0] tag;
    logic                 opd_valid;
    logic [ROB_WIDTH-1:0] opd_tag;
    logic [31:0]          data;
  } fmov_rs_entry;

  function automatic logic [31:0] apply_sign(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] r;
    unique case (op)
      FMOV:    r = d;
      FNEG:    r = {~d[31], d[30:0]};
      FABS:    r = {1'b0, d[30:0]};
      FNABS:   r = {1'b1, d[30:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  fmov_rs_entry ent_q [N_ENTRY];
  fmov_rs_entry ent_d [N_ENTRY];
  // cand[0..N_ENTRY-1] are stored entries after wakeup; cand[N_ENTRY] is the issuing instruction.
  fmov_rs_entry cand  [N_ENTRY+1];
  fmov_rs_entry nxt;

  logic [N_ENTRY:0] req;
  logic [N_ENTRY:0] gnt;
  logic             dispatch;
  logic             full;
  logic             issue_fire;
  logic             store_new;
  logic             removed;
  logic             placed;
  cdb_t             res_d;

  always_comb begin
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      cand[i] = ent_q[i];
      if (ent_q[i].valid && !ent_q[i].opd_valid && tag_match(cdb_in, ent_q[i].opd_tag)) begin
        cand[i].opd_valid = 1'b1;
        cand[i].data      = apply_sign(ent_q[i].op, cdb_in.data);
      end
      req[i] = cand[i].valid && cand[i].opd_valid;
    end
    cand[N_ENTRY].valid     = issue_valid;
    cand[N_ENTRY].op        = issue_op;
    cand[N_ENTRY].tag       = issue_tag;
    cand[N_ENTRY].opd_tag   = opd_in.tag;
    cand[N_ENTRY].opd_valid = opd_in.valid || tag_match(cdb_in, opd_in.tag);
    cand[N_ENTRY].data      = apply_sign(issue_op, opd_in.valid ? opd_in.data : cdb_in.data);
`ifdef FMOV_RS_BYPASS_EN
    req[N_ENTRY] = cand[N_ENTRY].valid && cand[N_ENTRY].opd_valid;
`else
    req[N_ENTRY] = 1'b0;
`endif
  end

  fmov_rs_pick #(
    .N_REQ(N_ENTRY + 1)
  ) u_pick (
    .req(req),
    .gnt(gnt),
    .any(cdb_req_valid)
  );

  assign full        = ent_q[N_ENTRY-1].valid;
  assign dispatch    = cdb_req_valid && cdb_req_ready;
  assign issue_ready = !full || dispatch;
  assign issue_fire  = issue_valid && issue_ready;
  assign store_new   = issue_fire && !(dispatch && gnt[N_ENTRY]);

  // Shift everything above the dispatched slot down, then drop the new entry in the first hole.
  always_comb begin
    removed = 1'b0;
    placed  = 1'b0;
    nxt     = '0;
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      removed = removed | (dispatch & gnt[i]);
      if (removed) nxt = (i == int'(N_ENTRY) - 1) ? '0 : cand[i+1];
      else         nxt = cand[i];
      if (!nxt.valid && store_new && !placed) begin
        nxt       = cand[N_ENTRY];
        nxt.valid = 1'b1;
        placed    = 1'b1;
      end
      ent_d[i] = nxt;
    end
  end

  always_comb begin
    res_d = '0;
    for (int i = 0; i <= int'(N_ENTRY); i++) begin
      if (gnt[i]) begin
        res_d.tag  = cand[i].tag;
        res_d.data = cand[i].data;
      end
    end
    res_d.valid = dispatch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_ENTRY); i++) ent_q[i] <= '0;
      result <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(N_ENTRY); i++) ent_q[i] <= '0;
      result <= '0;
    end else begin
      ent_q  <= ent_d;
      result <= res_d;
    end
  end

endmodule

// File: tb/tb_fmov_rs.sv
// Scoreboard bench for fmov_rs: expected results queued at issue, checked as results emerge.
module tb_fmov_rs;
  import fmov_rs_pkg::*;

  localparam int unsigned TW = fmov_rs_pkg::ROB_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          issue_valid;
  logic          issue_ready;
  logic [1:0]    issue_op;
  logic [TW-1:0] issue_tag;
  cdb_t          opd_in;
  cdb_t          cdb_in;
  logic          cdb_req_valid;
  logic          cdb_req_ready;
  cdb_t          result;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_lat1, exp_lat2;

  fmov_rs #(
    .N_ENTRY(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_op(issue_op),
    .issue_tag(issue_tag),
    .opd_in(opd_in),
    .cdb_in(cdb_in),
    .cdb_req_valid(cdb_req_valid),
    .cdb_req_ready(cdb_req_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sign(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return d ^ 32'h8000_0000;
      2'b10:   return d & 32'h7FFF_FFFF;
      default: return d | 32'h8000_0000;
    endcase
  endfunction

  task automatic expect_res(input logic [TW-1:0] tag, input logic [31:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input logic v, input logic [TW-1:0] tag, input logic [31:0] data);
    cdb_in = '{valid: v, tag: tag, data: data};
  endtask

  task automatic do_issue(input logic [1:0] op, input logic [TW-1:0] tag, input logic ov,
                          input logic [TW-1:0] otag, input logic [31:0] od);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    opd_in      = '{valid: ov, tag: otag, data: od};
    #1;
    check_val("iss_rdy", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    opd_in      = '0;
  endtask

  always @(negedge clk) begin
    if (reset && result.valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexp_res", result.valid, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("res_tag", result.tag, e.tag);
        check_val("res_data", result.data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_tag = '0;
    opd_in = '0; cdb_in = '0; cdb_req_ready = 1'b0;
`ifdef FMOV_RS_BYPASS_EN
    exp_lat1 = 1'b1; exp_lat2 = 1'b0;
`else
    exp_lat1 = 1'b0; exp_lat2 = 1'b1;
`endif
    #12;
    check_val("rst_iss_rdy", issue_ready, 1);
    check_val("rst_req", cdb_req_valid, 0);
    check_val("rst_res", result.valid, 0);
    tick();
    reset = 1'b1;

    // fneg of a ready operand with grant held high
    cdb_req_ready = 1'b1;
    expect_res(7, 32'hBF80_0000);
    do_issue(2'b01, 7, 1'b1, 0, 32'h3F80_0000);
    @(negedge clk); check_val("lat_1", result.valid, exp_lat1);
    @(negedge clk); check_val("lat_2", result.valid, exp_lat2);

    // fabs waiting on tag 5, woken by the CDB
    do_issue(2'b10, 9, 1'b0, 5, 0);
    #1 check_val("wait_noreq", cdb_req_valid, 0);
    expect_res(9, 32'h4040_0000);
    set_cdb(1'b1, 5, 32'hC040_0000);
    #1 check_val("wake_req", cdb_req_valid, 1);
    tick();
    cdb_in = '0;
    @(negedge clk); check_val("wake_res_v", result.valid, 1);

    // fill, wake out of order, drain oldest first
    cdb_req_ready = 1'b0;
    do_issue(2'b01, 11, 1'b0, 1, 0);
    do_issue(2'b00, 12, 1'b0, 2, 0);
    do_issue(2'b11, 13, 1'b0, 3, 0);
    do_issue(2'b01, 14, 1'b0, 4, 0);
    #1 check_val("full_rdy", issue_ready, 0);
    check_val("full_noreq", cdb_req_valid, 0);
    set_cdb(1'b1, 3, 32'h1234_5678); tick();
    set_cdb(1'b1, 1, 32'h8000_0001); tick();
    cdb_in = '0;
    expect_res(11, 32'h0000_0001);
    expect_res(13, 32'h9234_5678);
    #1 check_val("woke_req", cdb_req_valid, 1);
    check_val("full_rdy2", issue_ready, 0);
    cdb_req_ready = 1'b1; tick(); tick();
    cdb_req_ready = 1'b0;

    // full with simultaneous issue and dispatch
    do_issue(2'b10, 15, 1'b0, 6, 0);
    do_issue(2'b00, 16, 1'b1, 0, 32'hAAAA_5555);
    #1 check_val("full_rdy3", issue_ready, 0);
    check_val("full_req", cdb_req_valid, 1);
    expect_res(16, 32'hAAAA_5555);
    expect_res(17, 32'h8000_0000);
    issue_valid = 1'b1; issue_op = 2'b01; issue_tag = 17;
    opd_in = '{valid: 1'b1, tag: 0, data: 32'h0};
    cdb_req_ready = 1'b1;
    #1 check_val("fi_iss_rdy", issue_ready, 1);
    tick();
    issue_valid = 1'b0; opd_in = '0; cdb_req_ready = 1'b0;
    #1 check_val("still_full", issue_ready, 0);
    check_val("fi_req", cdb_req_valid, 1);
    cdb_req_ready = 1'b1; tick();
    expect_res(15, 32'h3F00_0000); set_cdb(1'b1, 6, 32'hBF00_0000); tick();
    expect_res(12, 32'h0000_0002); set_cdb(1'b1, 2, 32'h0000_0002); tick();
    expect_res(14, 32'hC000_0000); set_cdb(1'b1, 4, 32'h4000_0000); tick();
    cdb_in = '0; cdb_req_ready = 1'b0;
    #1 check_val("drain_rdy", issue_ready, 1);
    check_val("drain_req", cdb_req_valid, 0);

    // flush overrides a concurrent issue and grant
    do_issue(2'b00, 20, 1'b1, 0, 32'h1);
    flush = 1'b1; issue_valid = 1'b1; issue_op = 2'b00; issue_tag = 21;
    opd_in = '{valid: 1'b1, tag: 0, data: 32'h5};
    cdb_req_ready = 1'b1;
    tick();
    flush = 1'b0; issue_valid = 1'b0; opd_in = '0; cdb_req_ready = 1'b0;
    #1 check_val("fl_rdy", issue_ready, 1);
    check_val("fl_req", cdb_req_valid, 0);
    @(negedge clk); check_val("fl_res", result.valid, 0);

    // asynchronous reset with pending entries
    do_issue(2'b00, 30, 1'b1, 0, 32'h10);
    do_issue(2'b00, 31, 1'b1, 0, 32'h11);
    do_issue(2'b00, 32, 1'b1, 0, 32'h12);
    #1 check_val("pre_rst_req", cdb_req_valid, 1);
    #2 reset = 1'b0;
    #1 check_val("mr_req", cdb_req_valid, 0);
    check_val("mr_rdy", issue_ready, 1);
    check_val("mr_res", result.valid, 0);
    tick();
    reset = 1'b1;
    cdb_req_ready = 1'b1;
    expect_res(33, 32'h8000_0001);
    do_issue(2'b11, 33, 1'b1, 0, 32'h0000_0001);
    repeat (3) tick();

    // back-to-back ready operands, mixed ops
    for (int k = 0; k < 8; k++) begin
      logic [1:0]  op;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      expect_res(TW'(40 + k), exp_sign(op, d));
      do_issue(op, TW'(40 + k), 1'b1, 0, d);
    end
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) tick();
    cdb_req_ready = 1'b0;
    repeat (2) tick();
    check_val("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
